// File: rtl/histeq_pkg.sv
// ============================================================================
// Module : histeq_pkg
// Brief  : Shared constants, FSM encoding and m3 address forming for the
//          histogram-equalizer output stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package histeq_pkg;

  localparam logic [15:0] MAP_TAG      = 16'hAAAA;
  localparam int          PIX_PER_WORD = 16;
  localparam int          WORD_W       = 128;
  localparam int          ADDR_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_MAP   = 3'd3,
    S_DRAIN = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // The map bank bit sits directly above the 8-bit pixel value.
  function automatic logic [ADDR_W-1:0] m3_addr(input logic bank, input logic [7:0] pix);
    return {7'b0, bank, pix};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_packer.sv
// ============================================================================
// Module : lane_packer
// Brief  : 16 x 8-bit lane register assembling one 128-bit output word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_packer
  import histeq_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_we,
  input  logic [3:0]        i_lane,
  input  logic [7:0]        i_data,
  output logic [WORD_W-1:0] o_word
);

  generate
    for (genvar g = 0; g < PIX_PER_WORD; g++) begin : g_lane
      logic [7:0] r_byte;

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          r_byte <= 8'h00;
        end else if (i_clear) begin
          r_byte <= 8'h00;
        end else if (i_we && (i_lane == 4'(g))) begin
          r_byte <= i_data;
        end
      end

      assign o_word[8*g +: 8] = r_byte;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/output_pipeline.sv
// ============================================================================
// Module : output_pipeline
// Brief  : Re-reads image words from m1, maps each pixel through the m3
//          equalization map and writes packed words to m4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module output_pipeline #(
  parameter int          NUM_WORDS = 4,
  parameter logic [15:0] MAP_TAG   = histeq_pkg::MAP_TAG
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mapBaseOffset,
  input  logic [127:0] m1ReadVal,
  input  logic [127:0] m3ReadVal,
  output logic [15:0]  m1ReadAddr,
  output logic [15:0]  m3ReadAddr,
  output logic [15:0]  m4WriteAddr,
  output logic [127:0] m4WriteVal,
  output logic         m4WE,
  output logic         done,
  output logic         tagErr
);

  import histeq_pkg::*;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_word_cnt;
  logic [3:0]          r_pix_idx;
  logic [3:0]          w_pix_idx_next;
  logic [WORD_W-1:0]   r_pix_word;
  logic                r_lkp_vld;
  logic [3:0]          r_lkp_lane;
  logic                w_last_word;
  logic                w_tag_ok;
  logic [7:0]          w_lane_byte;
  logic                w_m4we_next;
  logic                w_done_next;
  logic                w_unused;

  assign w_last_word    = (r_word_cnt == ADDR_W'(NUM_WORDS - 1));
  assign w_tag_ok       = (m3ReadVal[31:16] == MAP_TAG);
  assign w_lane_byte    = w_tag_ok ? m3ReadVal[7:0] : 8'h00;
  assign w_pix_idx_next = r_pix_idx + 4'd1;
  assign w_unused       = ^{m3ReadVal[127:32], m3ReadVal[15:8]};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_LATCH;
      S_LATCH: w_state_next = S_MAP;
      S_MAP:   if (r_pix_idx == 4'd15) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last_word ? S_DONE : S_FETCH;
      // Leaving DONE needs start low, so a held request cannot retrigger.
      S_DONE:  if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are flops aligned with it.
  always_comb begin
    w_m4we_next = (w_state_next == S_WRITE);
    w_done_next = (w_state_next == S_DONE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m4WE        <= 1'b0;
      done        <= 1'b0;
      m4WriteAddr <= '0;
    end else begin
      m4WE <= w_m4we_next;
      done <= w_done_next;
      if (w_m4we_next) m4WriteAddr <= r_word_cnt;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_pix_idx  <= '0;
      r_pix_word <= '0;
      m1ReadAddr <= '0;
      m3ReadAddr <= '0;
      tagErr     <= 1'b0;
      r_lkp_vld  <= 1'b0;
      r_lkp_lane <= '0;
    end else begin
      r_lkp_vld  <= (r_state == S_MAP);
      r_lkp_lane <= r_pix_idx;
      if (r_lkp_vld && !w_tag_ok) tagErr <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_word_cnt <= '0;
            m1ReadAddr <= '0;
            tagErr     <= 1'b0;
          end
        end
        // Lane 0 is issued straight from the returning m1 data.
        S_LATCH: begin
          r_pix_word <= m1ReadVal;
          r_pix_idx  <= '0;
          m3ReadAddr <= m3_addr(mapBaseOffset, m1ReadVal[7:0]);
        end
        S_MAP: begin
          r_pix_idx <= w_pix_idx_next;
          if (r_pix_idx != 4'd15) begin
            m3ReadAddr <= m3_addr(mapBaseOffset, r_pix_word[{w_pix_idx_next, 3'b000} +: 8]);
          end
        end
        S_WRITE: begin
          if (!w_last_word) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            m1ReadAddr <= r_word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  lane_packer u_lane_packer (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_clear (r_state == S_LATCH),
    .i_we    (r_lkp_vld),
    .i_lane  (r_lkp_lane),
    .i_data  (w_lane_byte),
    .o_word  (m4WriteVal)
  );

endmodule

`default_nettype wire

// File: tb/tb_output_pipeline.sv
// ============================================================================
// Module : tb_output_pipeline
// Brief  : Scoreboard bench for output_pipeline with m1/m3 memory models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_output_pipeline;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mapBaseOffset;
  logic [127:0] m1ReadVal;
  logic [127:0] m3ReadVal;
  logic [15:0]  m1ReadAddr;
  logic [15:0]  m3ReadAddr;
  logic [15:0]  m4WriteAddr;
  logic [127:0] m4WriteVal;
  logic         m4WE;
  logic         done;
  logic         tagErr;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
    int           at;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] m1_mem [0:3];
  logic [127:0] m3_mem [0:511];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           t0      = 0;

  output_pipeline #(.NUM_WORDS(4), .MAP_TAG(16'hAAAA)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .start         (start),
    .mapBaseOffset (mapBaseOffset),
    .m1ReadVal     (m1ReadVal),
    .m3ReadVal     (m3ReadVal),
    .m1ReadAddr    (m1ReadAddr),
    .m3ReadAddr    (m3ReadAddr),
    .m4WriteAddr   (m4WriteAddr),
    .m4WriteVal    (m4WriteVal),
    .m4WE          (m4WE),
    .done          (done),
    .tagErr        (tagErr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc       <= cyc + 1;
    m1ReadVal <= m1_mem[m1ReadAddr[1:0]];
    m3ReadVal <= m3_mem[m3ReadAddr[8:0]];
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_word(input logic [127:0] pix, input logic bank);
    logic [127:0] w;
    logic [127:0] ent;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      ent = m3_mem[{bank, pix[8*k +: 8]}];
      w[8*k +: 8] = (ent[31:16] == 16'hAAAA) ? ent[7:0] : 8'h00;
    end
    return w;
  endfunction

  always @(negedge clock) begin
    if (rst_n === 1'b1 && m4WE === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_we", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("wr_addr", m4WriteAddr, e.addr);
        check_eq("wr_data", m4WriteVal, e.data);
        check_eq("wr_time", cyc - t0, e.at);
      end
    end
  end

  task automatic run_once(input logic bank, input int drop_at, input int abort_at,
                          input logic exp_tagerr);
    for (int n = 0; n < 4; n++) begin
      sb_q.push_back('{16'(n), model_word(m1_mem[n], bank), 19 + 20*n});
    end
    mapBaseOffset = bank;
    start = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    check_eq("tagerr_clr", tagErr, 0);
    for (int e = 1; e <= 80; e++) begin
      @(posedge clock); #1;
      if (e == drop_at) start = 1'b0;
      if (bank && e == 10) check_eq("m3addr_bank", m3ReadAddr, {7'b0, 1'b1, m1_mem[0][71:64]});
      if (e == 79) check_eq("done_early", done, 0);
      if (e == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_ctl", {m4WE, done, tagErr, m1ReadAddr, m3ReadAddr, m4WriteAddr}, 0);
        check_eq("abort_val", m4WriteVal, 0);
        sb_q.delete();
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        @(posedge clock); #1;
        return;
      end
    end
    check_eq("done_rise", done, 1);
    check_eq("tagerr_end", tagErr, exp_tagerr);
    check_eq("sb_empty", sb_q.size(), 0);
    if (start) begin
      repeat (3) @(posedge clock);
      #1 check_eq("done_hold", done, 1);
      start = 1'b0;
    end
    @(posedge clock); #1;
    check_eq("done_fall", done, 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mapBaseOffset = 1'b0;
    for (int v = 0; v < 256; v++) begin
      m3_mem[v]       = {$urandom(), $urandom(), $urandom(), 16'hAAAA, 8'h3C, 8'(255 - v)};
      m3_mem[256 + v] = {$urandom(), $urandom(), $urandom(), 16'hAAAA, 8'hC3, 8'(v) ^ 8'h5A};
    end
    m1_mem[0] = 128'h0F0E0D0C0B0A09080706050403020100;
    m1_mem[1] = 128'h8877665544332211FFEEDDCCBBAA9988;
    m1_mem[2] = 128'h102030405060708090A042B0C0D0E0F0;
    m1_mem[3] = 128'h55AA55AA00FF00FF13579BDF2468ACE0;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_ctl", {m4WE, done, tagErr, m1ReadAddr, m3ReadAddr, m4WriteAddr}, 0);
    check_eq("rst_val", m4WriteVal, 0);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // Bank 0, fully tagged map, start held through DONE.
    run_once(1'b0, -1, -1, 1'b0);
    check_eq("word0_exact", model_word(m1_mem[0], 1'b0) ^ 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 0);

    // Untagged entry for 0x42 zeroes its lane and latches tagErr.
    m3_mem[8'h42][31:16] = 16'h0000;
    run_once(1'b0, -1, -1, 1'b1);
    check_eq("tagerr_sticky", tagErr, 1);

    // Bank 1 run clears tagErr at start and maps through bank-1 entries.
    run_once(1'b1, -1, -1, 1'b0);
    m3_mem[8'h42][31:16] = 16'hAAAA;

    // Reset mid-run, then a full restart.
    run_once(1'b0, -1, 30, 1'b0);
    run_once(1'b0, -1, -1, 1'b0);

    // Start dropped mid-run: run completes, done lasts one cycle.
    run_once(1'b0, 25, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
